k423_regfile: RTL and testbench

- General-purpose register file for the k423 core; it is the consumer end of the write-back interface driven by the WB stage (rd valid, rd index, rd data).
- Provides two combinational read ports to ID, with a same-cycle WB-to-ID bypass.
- Includes a per-register in-flight scoreboard. ID sets an entry when it issues an instruction with a destination; the matching WB write clears it. ID stalls on read-after-write hazards using the busy outputs.

---
 rtl/k423_regfile_pkg.sv | 26 ++
 rtl/k423_scoreboard.sv | 92 +++++++++
 rtl/k423_regfile.sv | 71 +++++++
 tb/tb_k423_regfile.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/k423_regfile_pkg.sv
// Shared constants for the k423 register file and its in-flight scoreboard.
package k423_regfile_pkg;

  // Data width of one general-purpose register.
  localparam int XLEN     = 32;
  // Number of architectural registers; x0 reads as zero.
  localparam int REG_NUM  = 32;
  // Register index width.
  localparam int IDX_W    = $clog2(REG_NUM);
  // Per-register in-flight counter width (EX/MEM/WB -> up to 3 writes).
  localparam int SB_CNT_W = 2;

  // Saturation point of an in-flight counter.
  localparam logic [SB_CNT_W-1:0] SB_CNT_MAX = {SB_CNT_W{1'b1}};

  // Index zero, used for the hardwired x0 checks.
  localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};

  // True when a WB write to 'wb_idx' retires into register 'idx'.
  function automatic logic idx_hit(input logic             vld,
                                   input logic [IDX_W-1:0] wb_idx,
                                   input logic [IDX_W-1:0] idx);
    return vld & (wb_idx == idx);
  endfunction

endpackage

// File: rtl/k423_scoreboard.sv
// In-flight write scoreboard: one saturating counter per register, set by
// ID issue, cleared by WB retire, with busy lookup and sticky error flag.
module k423_scoreboard
  import k423_regfile_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             id_issue_vld_i,
  input  logic             id_rd_vld_i,
  input  logic [IDX_W-1:0] id_rd_idx_i,
  input  logic             wb_rd_vld_i,
  input  logic [IDX_W-1:0] wb_rd_idx_i,
  input  logic [IDX_W-1:0] rs1_idx_i,
  input  logic [IDX_W-1:0] rs2_idx_i,
  output logic             rs1_busy_o,
  output logic             rs2_busy_o,
  output logic             sb_err_o
);

  logic [SB_CNT_W-1:0] cnt_r   [REG_NUM];
  logic [SB_CNT_W-1:0] cnt_nxt [REG_NUM];
  logic [REG_NUM-1:0]  inc_s;
  logic [REG_NUM-1:0]  dec_s;
  logic                ovf_s;
  logic                udf_s;
  logic                err_r;
  logic [SB_CNT_W-1:0] rs1_left_s;
  logic [SB_CNT_W-1:0] rs2_left_s;

  // Decode issue and retire events per register; x0 never counts.
  always_comb begin
    inc_s = {REG_NUM{1'b0}};
    dec_s = {REG_NUM{1'b0}};
    for (int r = 1; r < REG_NUM; r++) begin
      inc_s[r] = id_issue_vld_i & id_rd_vld_i & (id_rd_idx_i == IDX_W'(r));
      dec_s[r] = wb_rd_vld_i & (wb_rd_idx_i == IDX_W'(r));
    end
  end

  // Next counter values; saturate at both ends and flag the attempt.
  always_comb begin
    ovf_s = 1'b0;
    udf_s = 1'b0;
    for (int r = 0; r < REG_NUM; r++) begin
      cnt_nxt[r] = cnt_r[r];
      if (inc_s[r] && !dec_s[r]) begin
        if (cnt_r[r] == SB_CNT_MAX) begin
          ovf_s = 1'b1;
        end else begin
          cnt_nxt[r] = cnt_r[r] + {{(SB_CNT_W-1){1'b0}}, 1'b1};
        end
      end else if (dec_s[r] && !inc_s[r]) begin
        if (cnt_r[r] == {SB_CNT_W{1'b0}}) begin
          udf_s = 1'b1;
        end else begin
          cnt_nxt[r] = cnt_r[r] - {{(SB_CNT_W-1){1'b0}}, 1'b1};
        end
      end else begin
        cnt_nxt[r] = cnt_r[r];
      end
    end
  end

  // Counter array and sticky error register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      for (int r = 0; r < REG_NUM; r++) begin
        cnt_r[r] <= {SB_CNT_W{1'b0}};
      end
      err_r <= 1'b0;
    end else begin
      for (int r = 0; r < REG_NUM; r++) begin
        cnt_r[r] <= cnt_nxt[r];
      end
      err_r <= err_r | ovf_s | udf_s;
    end
  end

  // Busy from the pre-edge count, discounting a write retiring this cycle
  // (that value is bypassed, so the reader need not wait for it).
  always_comb begin
    rs1_left_s = cnt_r[rs1_idx_i]
               - {{(SB_CNT_W-1){1'b0}}, idx_hit(wb_rd_vld_i, wb_rd_idx_i, rs1_idx_i)};
    rs2_left_s = cnt_r[rs2_idx_i]
               - {{(SB_CNT_W-1){1'b0}}, idx_hit(wb_rd_vld_i, wb_rd_idx_i, rs2_idx_i)};
    rs1_busy_o = (rs1_idx_i != IDX_ZERO) & (rs1_left_s != {SB_CNT_W{1'b0}});
    rs2_busy_o = (rs2_idx_i != IDX_ZERO) & (rs2_left_s != {SB_CNT_W{1'b0}});
  end

  assign sb_err_o = err_r;

endmodule

// File: rtl/k423_regfile.sv
// k423 general-purpose register file: WB write port, two combinational read
// ports with same-cycle WB bypass, and the in-flight scoreboard.
module k423_regfile
  import k423_regfile_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             id_issue_vld_i,
  input  logic             id_rd_vld_i,
  input  logic [IDX_W-1:0] id_rd_idx_i,
  input  logic             wb_rd_vld_i,
  input  logic [IDX_W-1:0] wb_rd_idx_i,
  input  logic [XLEN-1:0]  wb_rd_i,
  input  logic [IDX_W-1:0] rs1_idx_i,
  input  logic [IDX_W-1:0] rs2_idx_i,
  output logic [XLEN-1:0]  rs1_o,
  output logic [XLEN-1:0]  rs2_o,
  output logic             rs1_busy_o,
  output logic             rs2_busy_o,
  output logic             sb_err_o
);

  logic [XLEN-1:0] gpr_r [REG_NUM];

  // Register storage; writes to x0 are dropped so it stays zero.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      for (int r = 0; r < REG_NUM; r++) begin
        gpr_r[r] <= {XLEN{1'b0}};
      end
    end else if (wb_rd_vld_i && (wb_rd_idx_i != IDX_ZERO)) begin
      gpr_r[wb_rd_idx_i] <= wb_rd_i;
    end
  end

  // Read ports: x0 is zero, a matching WB write is bypassed, else storage.
  always_comb begin
    rs1_o = {XLEN{1'b0}};
    rs2_o = {XLEN{1'b0}};
    if (rs1_idx_i == IDX_ZERO) begin
      rs1_o = {XLEN{1'b0}};
    end else if (idx_hit(wb_rd_vld_i, wb_rd_idx_i, rs1_idx_i)) begin
      rs1_o = wb_rd_i;
    end else begin
      rs1_o = gpr_r[rs1_idx_i];
    end
    if (rs2_idx_i == IDX_ZERO) begin
      rs2_o = {XLEN{1'b0}};
    end else if (idx_hit(wb_rd_vld_i, wb_rd_idx_i, rs2_idx_i)) begin
      rs2_o = wb_rd_i;
    end else begin
      rs2_o = gpr_r[rs2_idx_i];
    end
  end

  k423_scoreboard u_scoreboard (
    .clk_i          (clk_i),
    .rst_n_i        (rst_n_i),
    .id_issue_vld_i (id_issue_vld_i),
    .id_rd_vld_i    (id_rd_vld_i),
    .id_rd_idx_i    (id_rd_idx_i),
    .wb_rd_vld_i    (wb_rd_vld_i),
    .wb_rd_idx_i    (wb_rd_idx_i),
    .rs1_idx_i      (rs1_idx_i),
    .rs2_idx_i      (rs2_idx_i),
    .rs1_busy_o     (rs1_busy_o),
    .rs2_busy_o     (rs2_busy_o),
    .sb_err_o       (sb_err_o)
  );

endmodule

// File: tb/tb_k423_regfile.sv
// Self-checking bench for k423_regfile: directed scenarios then random
// traffic, all compared against a behavioural register/scoreboard model.
module tb_k423_regfile;

  logic        clk;
  logic        rst_n;
  logic        id_issue_vld;
  logic        id_rd_vld;
  logic [4:0]  id_rd_idx;
  logic        wb_rd_vld;
  logic [4:0]  wb_rd_idx;
  logic [31:0] wb_rd;
  logic [4:0]  rs1_idx;
  logic [4:0]  rs2_idx;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        rs1_busy;
  logic        rs2_busy;
  logic        sb_err;

  // Behavioural model: architectural values, outstanding-write counts, error.
  logic [31:0] m_gpr [32];
  int          m_cnt [32];
  bit          m_err;

  int n_vec;
  int n_err;

  k423_regfile dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .id_issue_vld_i (id_issue_vld),
    .id_rd_vld_i    (id_rd_vld),
    .id_rd_idx_i    (id_rd_idx),
    .wb_rd_vld_i    (wb_rd_vld),
    .wb_rd_idx_i    (wb_rd_idx),
    .wb_rd_i        (wb_rd),
    .rs1_idx_i      (rs1_idx),
    .rs2_idx_i      (rs2_idx),
    .rs1_o          (rs1),
    .rs2_o          (rs2),
    .rs1_busy_o     (rs1_busy),
    .rs2_busy_o     (rs2_busy),
    .sb_err_o       (sb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_read(input logic [4:0] idx, input logic wv,
                                           input logic [4:0] wi, input logic [31:0] wd);
    if (idx == 5'd0) return 32'd0;
    if (wv && wi == idx) return wd;
    return m_gpr[idx];
  endfunction

  function automatic logic exp_busy(input logic [4:0] idx, input logic wv, input logic [4:0] wi);
    int pending;
    if (idx == 5'd0) return 1'b0;
    pending = m_cnt[idx] - ((wv && wi == idx) ? 1 : 0);
    return pending != 0;
  endfunction

  // One cycle: drive at the falling edge, check mid-cycle, advance the model
  // at the rising edge.
  task automatic step(input logic rst, input logic iv, input logic rv, input logic [4:0] ri,
                      input logic wv, input logic [4:0] wi, input logic [31:0] wd,
                      input logic [4:0] a, input logic [4:0] b, input bit do_chk);
    @(negedge clk);
    rst_n = rst; id_issue_vld = iv; id_rd_vld = rv; id_rd_idx = ri;
    wb_rd_vld = wv; wb_rd_idx = wi; wb_rd = wd; rs1_idx = a; rs2_idx = b;
    #1;
    if (do_chk) begin
      chk("rs1", rs1, exp_read(a, wv, wi, wd));
      chk("rs2", rs2, exp_read(b, wv, wi, wd));
      chk("rs1_busy", {31'd0, rs1_busy}, {31'd0, exp_busy(a, wv, wi)});
      chk("rs2_busy", {31'd0, rs2_busy}, {31'd0, exp_busy(b, wv, wi)});
      chk("sb_err", {31'd0, sb_err}, {31'd0, m_err});
    end
    @(posedge clk);
    if (!rst) begin
      for (int r = 0; r < 32; r++) begin
        m_gpr[r] = 32'd0;
        m_cnt[r] = 0;
      end
      m_err = 1'b0;
    end else begin
      if (wv && wi != 5'd0) m_gpr[wi] = wd;
      for (int r = 1; r < 32; r++) begin
        bit inc;
        bit dec;
        inc = iv && rv && ri == r[4:0];
        dec = wv && wi == r[4:0];
        if (inc && !dec) begin
          if (m_cnt[r] == 3) m_err = 1'b1; else m_cnt[r]++;
        end else if (dec && !inc) begin
          if (m_cnt[r] == 0) m_err = 1'b1; else m_cnt[r]--;
        end
      end
    end
  endtask

  // Idle cycle with read ports on a and b.
  task automatic rd(input logic [4:0] a, input logic [4:0] b);
    step(1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, a, b, 1'b1);
  endtask

  task automatic issue(input logic [4:0] ri, input logic [4:0] a);
    step(1'b1, 1'b1, 1'b1, ri, 1'b0, 5'd0, 32'd0, a, a, 1'b1);
  endtask

  task automatic wb(input logic [4:0] wi, input logic [31:0] wd, input logic [4:0] a, input logic [4:0] b);
    step(1'b1, 1'b0, 1'b0, 5'd0, 1'b1, wi, wd, a, b, 1'b1);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0);
  endtask

  initial begin
    logic [4:0] q [$];
    n_vec = 0;
    n_err = 0;
    m_err = 1'b0;
    for (int r = 0; r < 32; r++) begin
      m_gpr[r] = 32'd0;
      m_cnt[r] = 0;
    end
    rst_n = 1'b0; id_issue_vld = 1'b0; id_rd_vld = 1'b0; id_rd_idx = 5'd0;
    wb_rd_vld = 1'b0; wb_rd_idx = 5'd0; wb_rd = 32'd0; rs1_idx = 5'd0; rs2_idx = 5'd0;
    do_reset();
    do_reset();

    // Reset state over every index.
    for (int i = 0; i < 32; i++) begin
      rd(i[4:0], 5'(31 - i));
      chk("reset_rs1_zero", rs1, 32'd0);
    end

    // Plain write then read; x0 write dropped.
    issue(5'd5, 5'd5);
    wb(5'd5, 32'hDEADBEEF, 5'd0, 5'd0);
    rd(5'd5, 5'd0);
    chk("x5_readback", rs1, 32'hDEADBEEF);
    wb(5'd0, 32'h0000_1234, 5'd0, 5'd0);
    rd(5'd0, 5'd0);
    chk("x0_zero", rs1, 32'd0);

    // Same-cycle bypass over an older value.
    issue(5'd7, 5'd7);
    wb(5'd7, 32'h0000_0011, 5'd7, 5'd7);
    issue(5'd7, 5'd7);
    wb(5'd7, 32'h0000_0022, 5'd0, 5'd7);
    chk("bypass_x7", rs2, 32'h0000_0022);
    rd(5'd0, 5'd7);

    // Two writes in flight to x3, retired one at a time.
    issue(5'd3, 5'd3);
    issue(5'd3, 5'd3);
    rd(5'd3, 5'd3);
    chk("x3_busy2", {31'd0, rs1_busy}, 32'd1);
    wb(5'd3, 32'hA5A5_0001, 5'd3, 5'd0);
    wb(5'd3, 32'hA5A5_0002, 5'd3, 5'd3);
    chk("x3_last_retire_free", {31'd0, rs1_busy}, 32'd0);
    rd(5'd3, 5'd3);

    // Simultaneous issue and retire on x4; issue to x0.
    issue(5'd4, 5'd4);
    step(1'b1, 1'b1, 1'b1, 5'd4, 1'b1, 5'd4, 32'h0000_0044, 5'd4, 5'd4, 1'b1);
    rd(5'd4, 5'd0);
    chk("x4_still_busy", {31'd0, rs1_busy}, 32'd1);
    issue(5'd0, 5'd0);
    rd(5'd0, 5'd0);
    wb(5'd4, 32'h0000_0045, 5'd4, 5'd4);
    rd(5'd4, 5'd4);

    // Overflow on x9.
    for (int i = 0; i < 4; i++) issue(5'd9, 5'd9);
    rd(5'd9, 5'd9);
    chk("ovf_err", {31'd0, sb_err}, 32'd1);

    // Reset clears, then underflow on x9.
    do_reset();
    rd(5'd9, 5'd5);
    wb(5'd9, 32'h0000_0099, 5'd0, 5'd0);
    rd(5'd9, 5'd0);
    chk("udf_err", {31'd0, sb_err}, 32'd1);
    do_reset();
    rd(5'd9, 5'd3);
    chk("err_cleared", {31'd0, sb_err}, 32'd0);

    // Random traffic; retires mostly target registers with writes in flight.
    for (int n = 0; n < 600; n++) begin
      logic        iv;
      logic [4:0]  ri;
      logic        wv;
      logic [4:0]  wi;
      q.delete();
      for (int r = 1; r < 32; r++) if (m_cnt[r] > 0) q.push_back(r[4:0]);
      iv = ($urandom_range(0, 99) < 50);
      ri = 5'($urandom_range(0, 31));
      if (iv && ri != 5'd0 && m_cnt[ri] == 3 && $urandom_range(0, 9) != 0) iv = 1'b0;
      wv = 1'b0;
      wi = 5'($urandom_range(0, 31));
      if (q.size() > 0 && $urandom_range(0, 99) < 55) begin
        wv = 1'b1;
        wi = q[$urandom_range(0, q.size() - 1)];
      end else if ($urandom_range(0, 99) < 3) begin
        wv = 1'b1;
      end
      step(($urandom_range(0, 199) != 0), iv, ($urandom_range(0, 9) != 0), ri, wv, wi, $urandom(),
           5'($urandom_range(0, 31)), (wv && $urandom_range(0, 1) == 1) ? wi : 5'($urandom_range(0, 31)),
           1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
